// File: rtl/bosalt_pkg.sv
// bosalt_pkg: shared FSM state encoding and default word width for bosalt.
package bosalt_pkg;
   localparam int W_DEF = 32;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UST  = 2'd1,
      ALT  = 2'd2
   } state_e;
endpackage

// File: rtl/bosalt.sv
// bosalt: unpacks each accepted 2*W word into two W words, upper half first.
// Streams back-to-back by reloading from the lower-half cycle.
module bosalt
   import bosalt_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [2*W-1:0] depo,
   input  logic           depo_valid,
   output logic           depo_ready,
   output logic [W-1:0]   veri,
   output logic           veri_valid,
   input  logic           veri_ready,
   output logic           bos,
   output logic [15:0]    sayac
);
   state_e         state_q;
   logic [2*W-1:0] hold_q;
   logic [W-1:0]   veri_q;
   logic           vld_q;
   logic           bos_q;
   logic [15:0]    sayac_q;
   logic           accept;
   // rst_n gates ready so nothing is offered while reset is held
   assign depo_ready = rst_n & ((state_q == IDLE) | ((state_q == ALT) & veri_ready));
   assign accept     = depo_valid & depo_ready;
   assign veri       = veri_q;
   assign veri_valid = vld_q;
   assign bos        = bos_q;
   assign sayac      = sayac_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         veri_q  <= '0;
         vld_q   <= 1'b0;
         bos_q   <= 1'b1;
         sayac_q <= '0;
      end else begin
         if (vld_q && veri_ready) sayac_q <= sayac_q + 16'd1;
         if (accept) begin
            hold_q  <= depo;
            veri_q  <= depo[2*W-1:W];
            vld_q   <= 1'b1;
            bos_q   <= 1'b0;
            state_q <= UST;
         end else begin
            case (state_q)
               UST: if (veri_ready) begin
                  state_q <= ALT;
                  veri_q  <= hold_q[W-1:0];
               end
               ALT: if (veri_ready) begin
                  state_q <= IDLE;
                  veri_q  <= '0;
                  vld_q   <= 1'b0;
                  bos_q   <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_bosalt.sv
// tb_bosalt: directed self-checking bench for bosalt.
module tb_bosalt;
   localparam int W = 32;
   logic           clk = 1'b0;
   logic           rst_n;
   logic [2*W-1:0] depo;
   logic           depo_valid;
   logic           depo_ready;
   logic [W-1:0]   veri;
   logic           veri_valid;
   logic           veri_ready;
   logic           bos;
   logic [15:0]    sayac;
   int             vectors = 0;
   int             miscompares = 0;
   logic [15:0]    exp_cnt = 16'd0;

   bosalt #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .depo(depo), .depo_valid(depo_valid),
      .depo_ready(depo_ready), .veri(veri), .veri_valid(veri_valid),
      .veri_ready(veri_ready), .bos(bos), .sayac(sayac)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b1; depo = '0; depo_valid = 1'b0; veri_ready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) step();
      vectors++;
      if (depo_ready !== 1'b0 || bos !== 1'b1 || veri_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold: ready=%b bos=%b vld=%b want 0 1 0", depo_ready, bos, veri_valid);
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (veri !== '0 || veri_valid !== 1'b0 || bos !== 1'b1 || sayac !== 16'd0 || depo_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release: veri=%h vld=%b bos=%b sayac=%h ready=%b want 0 0 1 0 1",
                  veri, veri_valid, bos, sayac, depo_ready);
      end
      exp_cnt = 16'd0;
   endtask

   task automatic test_single;
      depo = 64'h1111_2222_3333_4444; depo_valid = 1'b1; veri_ready = 1'b1;
      step();
      depo_valid = 1'b0;
      #1;
      vectors++;
      if (veri !== 32'h1111_2222 || veri_valid !== 1'b1 || depo_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL single_upper: veri=%h vld=%b ready=%b want 11112222 1 0", veri, veri_valid, depo_ready);
      end
      step();
      vectors++;
      if (veri !== 32'h3333_4444 || veri_valid !== 1'b1 || depo_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL single_lower: veri=%h vld=%b ready=%b want 33334444 1 1", veri, veri_valid, depo_ready);
      end
      step();
      exp_cnt += 16'd2;
      vectors++;
      if (bos !== 1'b1 || veri_valid !== 1'b0 || veri !== '0 || sayac !== exp_cnt) begin
         miscompares++;
         $display("FAIL single_idle: bos=%b vld=%b veri=%h sayac=%0d want 1 0 0 %0d",
                  bos, veri_valid, veri, sayac, exp_cnt);
      end
   endtask

   task automatic test_backpressure;
      depo = 64'h1111_2222_3333_4444; depo_valid = 1'b1; veri_ready = 1'b0;
      step();
      depo = 64'hBAD0_BAD0_BAD0_BAD0;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (veri !== 32'h1111_2222 || veri_valid !== 1'b1 || depo_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold%0d: veri=%h vld=%b ready=%b want 11112222 1 0",
                     i, veri, veri_valid, depo_ready);
         end
         step();
      end
      veri_ready = 1'b1; depo_valid = 1'b0;
      step();
      vectors++;
      if (veri !== 32'h3333_4444 || veri_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_lower: veri=%h vld=%b want 33334444 1", veri, veri_valid);
      end
      step();
      exp_cnt += 16'd2;
      vectors++;
      if (bos !== 1'b1 || sayac !== exp_cnt) begin
         miscompares++;
         $display("FAIL bp_idle: bos=%b sayac=%0d want 1 %0d", bos, sayac, exp_cnt);
      end
   endtask

   function automatic logic [63:0] word(int i);
      logic [31:0] b;
      b = 32'hA000_0000 + 32'(2 * i);
      return {b, b + 32'd1};
   endfunction

   task automatic test_back_to_back;
      logic [63:0] w;
      int bad = 0;
      depo = word(0); depo_valid = 1'b1; veri_ready = 1'b1;
      step();
      for (int k = 0; k < 28; k++) begin
         w = word(k / 2);
         if (veri !== ((k % 2 == 0) ? w[63:32] : w[31:0]) || veri_valid !== 1'b1) bad++;
         if (k % 2 == 1) depo = word(k / 2 + 1);
         if (k == 27) depo_valid = 1'b0;
         step();
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL stream_order: %0d bad beats want 0", bad);
      end
      exp_cnt += 16'd28;
      vectors++;
      if (bos !== 1'b1 || sayac !== exp_cnt) begin
         miscompares++;
         $display("FAIL stream_end: bos=%b sayac=%0d want 1 %0d", bos, sayac, exp_cnt);
      end
   endtask

   task automatic test_wrap;
      depo = 64'h0123_4567_89AB_CDEF; depo_valid = 1'b1; veri_ready = 1'b1;
      step();
      while (exp_cnt != 16'hFFFF) begin
         step();
         exp_cnt++;
      end
      vectors++;
      if (sayac !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL wrap_pre: sayac=%h want ffff", sayac);
      end
      depo_valid = 1'b0;
      if (veri_valid) begin
         step();
         exp_cnt++;
      end
      vectors++;
      if (sayac !== 16'h0000) begin
         miscompares++;
         $display("FAIL wrap_post: sayac=%h want 0000", sayac);
      end
      while (!bos) step();
   endtask

   task automatic test_mid_reset;
      depo = 64'hDEAD_BEEF_CAFE_F00D; depo_valid = 1'b1; veri_ready = 1'b1;
      step();
      depo_valid = 1'b0;
      step();
      vectors++;
      if (veri !== 32'hCAFE_F00D || veri_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_alt: veri=%h vld=%b want cafef00d 1", veri, veri_valid);
      end
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (veri_valid !== 1'b0 || bos !== 1'b1 || veri !== '0 || depo_ready !== 1'b0 || sayac !== 16'd0) begin
         miscompares++;
         $display("FAIL mid_async: vld=%b bos=%b veri=%h ready=%b sayac=%h want 0 1 0 0 0",
                  veri_valid, bos, veri, depo_ready, sayac);
      end
      step();
      rst_n = 1'b1;
      #1;
      vectors++;
      if (depo_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_ready: ready=%b want 1", depo_ready);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (veri_valid !== 1'b0 || bos !== 1'b1 || veri !== '0) begin
            miscompares++;
            $display("FAIL mid_after%0d: vld=%b bos=%b veri=%h want 0 1 0", i, veri_valid, bos, veri);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_wrap();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/bosalt.md
BOSALT -- requirements
Module: bosalt

Interface
REQ-001 SHALL provide parameter W, default 32, width of one unpacked word; the packed word is 2*W.
REQ-002 SHALL have clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have depo  input  2*W  packed word from the upstream filling stage; {older word, newer word}.
REQ-005 SHALL have depo_valid  input  1  depo holds a word to be accepted.
REQ-006 SHALL have depo_ready  output  1  block accepts depo this cycle.
REQ-007 SHALL have veri  output  W  unpacked word.
REQ-008 SHALL have veri_valid  output  1  veri is valid.
REQ-009 SHALL have veri_ready  input  1  downstream accepts veri this cycle.
REQ-010 SHALL have bos  output  1  high when no packed word is held.
REQ-011 SHALL have sayac  output  16  count of words delivered downstream.

Function
REQ-012 SHALL implement an FSM with states IDLE, UST (emitting upper half) and ALT (emitting lower half).
REQ-013 SHALL accept a packed word only on a cycle where depo_valid and depo_ready are both 1.
REQ-014 SHALL drive depo_ready = 1 in IDLE, = veri_ready in ALT, = 0 in UST.
REQ-015 SHALL capture depo into an internal 2*W hold register on accept and enter UST on the next edge.
REQ-016 SHALL drive veri = hold[2W-1:W] in UST, hold[W-1:0] in ALT, and all-zero in IDLE.
REQ-017 SHALL drive veri_valid = 1 in UST and ALT, 0 in IDLE; bos = 1 exactly in IDLE.
REQ-018 SHALL hold veri and veri_valid stable while veri_valid = 1 and veri_ready = 0.
REQ-019 SHALL transition UST -> ALT on veri_ready = 1; otherwise stay in UST.
REQ-020 SHALL, in ALT with veri_ready = 1, load a new word and go to UST if depo_valid = 1, else go to IDLE.
REQ-021 SHALL present the upper half in the first cycle after accept (latency 1 cycle).
REQ-022 SHALL sustain 2 words per packed word, i.e., one packed word every 2 cycles with veri_ready held high and depo_valid held high, with no bubble between packed words.
REQ-023 SHALL increment sayac by 1 on every cycle with veri_valid and veri_ready both 1; 0xFFFF wraps to 0x0000.
REQ-024 SHALL ignore depo and depo_valid in UST and in ALT when veri_ready = 0; no word is lost or duplicated.

Reset
REQ-025 SHALL, while rst_n = 0, force state IDLE, hold = 0, veri = 0, veri_valid = 0, bos = 1, sayac = 0, depo_ready = 0.
REQ-026 SHALL drive depo_ready = 1 in the first cycle after rst_n deasserts.
REQ-027 SHALL discard a partially emitted packed word when reset asserts mid-operation; no remaining half is emitted after release.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE = 2'd0, UST = 2'd1, ALT = 2'd2) and the default W in shared package bosalt_pkg.
REQ-029 SHALL be a single module; the hold register, FSM and sayac counter are inline, with no sub-module.

Verification
REQ-030 Reset check: rst_n = 0 for 3 cycles, then release -> veri = 0, veri_valid = 0, bos = 1, sayac = 0; depo_ready = 1 on the first cycle after release.
REQ-031 Single word: depo = 64'h1111_2222_3333_4444, depo_valid for 1 cycle, veri_ready = 1 -> veri = 32'h1111_2222 next cycle, then 32'h3333_4444, then IDLE; sayac = 2.
REQ-032 Back-pressure: same word with veri_ready = 0 for 5 cycles in UST -> veri stays 32'h1111_2222, depo_ready = 0 throughout; release -> 32'h3333_4444 follows.
REQ-033 Streaming: 14 consecutive packed words with depo_valid and veri_ready held high -> 28 words out in order with no gap cycle; sayac = 28.
REQ-034 Wrap: preload the count to 16'hFFFF via 65535 word transfers, then one more transfer -> sayac = 16'h0000.
REQ-035 Mid-operation reset: assert rst_n = 0 while in ALT -> veri_valid = 0 immediately (asynchronously); after release the lower half is never emitted and bos = 1.
